cache_miss_sequencer: RTL and testbench

Miss-handling controller for the set-associative cache. It accepts one miss at a time from the lookup stage and writes back the dirty bytes of the victim line, one beat at a time with byte strobes. It then fetches the missing line as a burst and streams the fill beats into the chosen way of the data array. It is the only block that drives the cache's memory-side request port.

---
 rtl/cache_miss_sequencer.sv | 147 ++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer: writes back the dirty victim beats, then burst-fills the missing line into the chosen way.
// Define CACHE_MISS_SEQ_PERF_COUNTERS_EN to add saturating perf_* counter outputs.
module cache_miss_sequencer #(
    parameter int MINIMUM_ADDRESSIBLE_SIZE = 8,
    parameter int CACHE_BLOCK              = 512,
    parameter int MEM_BUS_WIDTH            = 64,
    parameter int ADDRESS_WIDTH            = 32,
    parameter int WAYS                     = 4,
    localparam int LB = CACHE_BLOCK / MINIMUM_ADDRESSIBLE_SIZE,
    localparam int BB = MEM_BUS_WIDTH / MINIMUM_ADDRESSIBLE_SIZE,
    localparam int NB = CACHE_BLOCK / MEM_BUS_WIDTH,
    localparam int WW = $clog2(WAYS),
    localparam int BW = $clog2(NB)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDRESS_WIDTH-1:0] miss_address,
    input  logic [WW-1:0]            miss_way,
    input  logic [ADDRESS_WIDTH-1:0] victim_address,
    input  logic [LB-1:0]            victim_dirty_mask,
    output logic [BW-1:0]            victim_beat,
    input  logic [MEM_BUS_WIDTH-1:0] victim_beat_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDRESS_WIDTH-1:0] mem_req_address,
    output logic [MEM_BUS_WIDTH-1:0] mem_wdata,
    output logic [BB-1:0]            mem_wstrb,
    input  logic                     mem_rvalid,
    input  logic [MEM_BUS_WIDTH-1:0] mem_rdata,
    output logic                     fill_valid,
    output logic [WW-1:0]            fill_way,
    output logic [BW-1:0]            fill_beat,
    output logic [MEM_BUS_WIDTH-1:0] fill_data,
    output logic                     done,
`ifdef CACHE_MISS_SEQ_PERF_COUNTERS_EN
    output logic [31:0]              perf_miss_count,
    output logic [31:0]              perf_wb_beat_count,
    output logic [31:0]              perf_stall_cycles,
`endif
    output logic                     busy
);
    localparam int BO = $clog2(BB);

    typedef enum logic [2:0] {IDLE, WB_BEAT, FILL_REQ, FILL_DATA, DONE} state_t;

    state_t                   state, state_n;
    logic [BW-1:0]            beat, beat_n;
    logic [ADDRESS_WIDTH-1:0] line_base, victim_base;
    logic [WW-1:0]            way;
    logic [LB-1:0]            dirty_mask;
    logic [BB-1:0]            slice;
    logic                     accept, wb_req, capture;

    assign slice   = dirty_mask[beat*BB +: BB];
    assign accept  = state == IDLE && miss_valid;
    assign wb_req  = state == WB_BEAT && |slice;
    assign capture = state == FILL_DATA && mem_rvalid;

    assign miss_ready      = state == IDLE;
    assign busy            = state != IDLE;
    assign done            = state == DONE;
    assign victim_beat     = state == WB_BEAT ? beat : '0;
    assign mem_req_valid   = wb_req || state == FILL_REQ;
    assign mem_req_write   = wb_req;
    assign mem_req_address = wb_req ? victim_base + ADDRESS_WIDTH'({beat, BO'(0)}) :
                             state == FILL_REQ ? line_base : '0;
    assign mem_wdata       = wb_req ? victim_beat_data : '0;
    assign mem_wstrb       = wb_req ? slice : '0;

    // next state and beat counter; clean beats are skipped in a single cycle, dirty ones wait for the handshake
    always_comb begin
        state_n = state;
        beat_n  = beat;
        case (state)
            IDLE: if (miss_valid) begin
                state_n = |victim_dirty_mask ? WB_BEAT : FILL_REQ;
                beat_n  = '0;
            end
            WB_BEAT: if (!wb_req || mem_req_ready) begin
                beat_n = beat + 1'b1;
                if (beat == BW'(NB - 1)) state_n = FILL_REQ;
            end
            FILL_REQ: if (mem_req_ready) state_n = FILL_DATA;
            FILL_DATA: begin
                if (mem_rvalid) beat_n = beat + 1'b1;
                if (fill_valid && fill_beat == BW'(NB - 1)) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, beat counter and miss fields latched on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            beat        <= '0;
            line_base   <= '0;
            victim_base <= '0;
            way         <= '0;
            dirty_mask  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            if (accept) begin
                line_base   <= miss_address & ~ADDRESS_WIDTH'(LB - 1);
                victim_base <= victim_address;
                way         <= miss_way;
                dirty_mask  <= victim_dirty_mask;
            end
        end
    end

    // fill port: each read beat lands in the data array one cycle after it arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_valid <= 1'b0;
            fill_way   <= '0;
            fill_beat  <= '0;
            fill_data  <= '0;
        end else begin
            fill_valid <= capture;
            if (capture) begin
                fill_way  <= way;
                fill_beat <= beat;
                fill_data <= mem_rdata;
            end
        end
    end

`ifdef CACHE_MISS_SEQ_PERF_COUNTERS_EN
    // saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_miss_count    <= '0;
            perf_wb_beat_count <= '0;
            perf_stall_cycles  <= '0;
        end else begin
            perf_miss_count    <= perf_miss_count + 32'(accept && !(&perf_miss_count));
            perf_wb_beat_count <= perf_wb_beat_count + 32'(wb_req && mem_req_ready && !(&perf_wb_beat_count));
            perf_stall_cycles  <= perf_stall_cycles + 32'(mem_req_valid && !mem_req_ready && !(&perf_stall_cycles));
        end
    end
`endif
endmodule

// File: tb/tb_cache_miss_sequencer.sv
// tb_cache_miss_sequencer: directed scenarios for the miss sequencer with hand-computed expectations.
module tb_cache_miss_sequencer;
    logic        clk, reset, miss_valid, miss_ready;
    logic [31:0] miss_address, victim_address, mem_req_address;
    logic [1:0]  miss_way, fill_way;
    logic [63:0] victim_dirty_mask, victim_beat_data, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  victim_beat, fill_beat;
    logic        mem_req_valid, mem_req_ready, mem_req_write, mem_rvalid, fill_valid, done, busy;
    logic [7:0]  mem_wstrb;
`ifdef CACHE_MISS_SEQ_PERF_COUNTERS_EN
    logic [31:0] perf_miss_count, perf_wb_beat_count, perf_stall_cycles;
`endif
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] VPAT = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] RPAT = 64'hD000_0000_0000_0000;

    assign victim_beat_data = VPAT | 64'(victim_beat);

    cache_miss_sequencer dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_address(miss_address),
        .miss_way(miss_way), .victim_address(victim_address), .victim_dirty_mask(victim_dirty_mask),
        .victim_beat(victim_beat), .victim_beat_data(victim_beat_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_address(mem_req_address), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_way(fill_way), .fill_beat(fill_beat), .fill_data(fill_data),
        .done(done),
`ifdef CACHE_MISS_SEQ_PERF_COUNTERS_EN
        .perf_miss_count(perf_miss_count), .perf_wb_beat_count(perf_wb_beat_count),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue_miss(input logic [31:0] a, input logic [1:0] w, input logic [31:0] va, input logic [63:0] m);
        miss_valid = 1; miss_address = a; miss_way = w; victim_address = va; victim_dirty_mask = m;
        @(negedge clk);
        miss_valid = 0; miss_address = 32'hFFFF_FFFF; miss_way = 2'd0;
        victim_address = 32'hDEAD_0000; victim_dirty_mask = '1;
    endtask

    task automatic fill_burst(input int n);
        for (int i = 0; i < n; i++) begin
            mem_rvalid = 1; mem_rdata = RPAT + 64'(i);
            @(negedge clk);
        end
        mem_rvalid = 0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        @(negedge clk);
    endtask

    task automatic wait_fill_req;
        for (int i = 0; i < 12 && !(mem_req_valid && !mem_req_write); i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1;
        @(negedge clk);
        checks++;
        if ({miss_ready, busy, done, mem_req_valid, mem_req_write, fill_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/busy/done/req/wr/fill=%b required 100000",
                     {miss_ready, busy, done, mem_req_valid, mem_req_write, fill_valid});
        end
        checks++;
        if (mem_req_address !== 0 || mem_wdata !== 0 || mem_wstrb !== 0 || victim_beat !== 0 ||
            fill_way !== 0 || fill_beat !== 0 || fill_data !== 0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h vbeat=%0d fway=%0d fbeat=%0d fdata=%h required all 0",
                     mem_req_address, mem_wdata, mem_wstrb, victim_beat, fill_way, fill_beat, fill_data);
        end
`ifdef CACHE_MISS_SEQ_PERF_COUNTERS_EN
        checks++;
        if (perf_miss_count !== 0 || perf_wb_beat_count !== 0 || perf_stall_cycles !== 0) begin
            errors++;
            $display("FAIL reset_perf: %0d %0d %0d required 0 0 0", perf_miss_count, perf_wb_beat_count, perf_stall_cycles);
        end
`endif
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_clean_miss;
        mem_req_ready = 1;
        issue_miss(32'h0000_1234, 2'd2, 32'h0000_8000, 64'd0);
        checks++;
        if (mem_req_valid !== 1 || mem_req_write !== 0 || mem_req_address !== 32'h0000_1200 ||
            mem_wstrb !== 0 || miss_ready !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL clean_read_req: valid=%b write=%b addr=%h wstrb=%h ready=%b busy=%b required 1 0 00001200 00 0 1",
                     mem_req_valid, mem_req_write, mem_req_address, mem_wstrb, miss_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 0) begin
            errors++;
            $display("FAIL clean_single_req: mem_req_valid=%b required 0", mem_req_valid);
        end
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1; mem_rdata = RPAT + 64'(i);
            @(negedge clk);
            mem_rvalid = 0;
            checks++;
            if (fill_valid !== 1 || fill_beat !== 3'(i) || fill_way !== 2'd2 || fill_data !== RPAT + 64'(i) || done !== 0) begin
                errors++;
                $display("FAIL clean_fill_beat%0d: valid=%b beat=%0d way=%0d data=%h done=%b required 1 %0d 2 %h 0",
                         i, fill_valid, fill_beat, fill_way, fill_data, done, i, RPAT + 64'(i));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1 || fill_valid !== 0) begin
            errors++;
            $display("FAIL clean_done: done=%b fill_valid=%b required 1 0", done, fill_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 0 || miss_ready !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL clean_idle: done=%b ready=%b busy=%b required 0 1 0", done, miss_ready, busy);
        end
    endtask

    task automatic test_full_dirty;
        bit seen;
        issue_miss(32'h0000_4444, 2'd1, 32'h0000_8000, '1);
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (mem_req_valid !== 1 || mem_req_write !== 1 || mem_req_address !== 32'h0000_8000 + 32'(8 * b) ||
                mem_wstrb !== 8'hFF || mem_wdata !== (VPAT | 64'(b)) || victim_beat !== 3'(b)) begin
                errors++;
                $display("FAIL dirty_write%0d: valid=%b write=%b addr=%h wstrb=%h wdata=%h vbeat=%0d required 1 1 %h ff %h %0d",
                         b, mem_req_valid, mem_req_write, mem_req_address, mem_wstrb, mem_wdata, victim_beat,
                         32'h0000_8000 + 32'(8 * b), VPAT | 64'(b), b);
            end
            @(negedge clk);
        end
        checks++;
        if (mem_req_valid !== 1 || mem_req_write !== 0 || mem_req_address !== 32'h0000_4440) begin
            errors++;
            $display("FAIL dirty_read_req: valid=%b write=%b addr=%h required 1 0 00004440",
                     mem_req_valid, mem_req_write, mem_req_address);
        end
        @(negedge clk);
        fill_burst(8);
        checks++;
        if (fill_valid !== 1 || fill_way !== 2'd1 || fill_beat !== 3'd7 || fill_data !== RPAT + 64'd7) begin
            errors++;
            $display("FAIL dirty_last_fill: valid=%b way=%0d beat=%0d data=%h required 1 1 7 %h",
                     fill_valid, fill_way, fill_beat, fill_data, RPAT + 64'd7);
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dirty_done: no done pulse within 10 cycles");
        end
    endtask

    task automatic test_sparse_dirty;
        bit seen;
        int wc = 0;
        int skips = 0;
        logic [31:0] wa [2];
        logic [7:0]  ws [2];
        wa[0] = 0; wa[1] = 0; ws[0] = 0; ws[1] = 0;
        issue_miss(32'h0000_5000, 2'd0, 32'h0000_8000, (64'h3 << 16) | (64'h1 << 47));
        for (int i = 0; i < 20 && !(mem_req_valid && !mem_req_write); i++) begin
            if (mem_req_valid && mem_req_write) begin
                if (wc < 2) begin wa[wc] = mem_req_address; ws[wc] = mem_wstrb; end
                wc++;
            end else skips++;
            @(negedge clk);
        end
        checks++;
        if (wc !== 2 || skips !== 6) begin
            errors++;
            $display("FAIL sparse_counts: writes=%0d skips=%0d required 2 6", wc, skips);
        end
        checks++;
        if (wa[0] !== 32'h0000_8010 || ws[0] !== 8'h03) begin
            errors++;
            $display("FAIL sparse_write0: addr=%h wstrb=%h required 00008010 03", wa[0], ws[0]);
        end
        checks++;
        if (wa[1] !== 32'h0000_8028 || ws[1] !== 8'h80) begin
            errors++;
            $display("FAIL sparse_write1: addr=%h wstrb=%h required 00008028 80", wa[1], ws[1]);
        end
        checks++;
        if (mem_req_valid !== 1 || mem_req_write !== 0 || mem_req_address !== 32'h0000_5000) begin
            errors++;
            $display("FAIL sparse_read_req: valid=%b write=%b addr=%h required 1 0 00005000",
                     mem_req_valid, mem_req_write, mem_req_address);
        end
        @(negedge clk);
        fill_burst(8);
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sparse_done: no done pulse within 10 cycles");
        end
    endtask

    task automatic test_backpressure;
        bit seen;
        mem_req_ready = 0;
        issue_miss(32'h0000_6000, 2'd3, 32'h0000_9000, 64'hFF);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (mem_req_valid !== 1 || mem_req_write !== 1 || mem_req_address !== 32'h0000_9000 ||
                mem_wdata !== VPAT || mem_wstrb !== 8'hFF) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b write=%b addr=%h wdata=%h wstrb=%h required 1 1 00009000 %h ff",
                         c, mem_req_valid, mem_req_write, mem_req_address, mem_wdata, mem_wstrb, VPAT);
            end
            if (c == 3) mem_req_ready = 1;
            @(negedge clk);
        end
        checks++;
        if (mem_req_valid !== 0 || victim_beat !== 3'd1) begin
            errors++;
            $display("FAIL bp_advance: valid=%b vbeat=%0d required 0 1", mem_req_valid, victim_beat);
        end
        wait_fill_req;
        checks++;
        if (mem_req_valid !== 1 || mem_req_write !== 0 || mem_req_address !== 32'h0000_6000) begin
            errors++;
            $display("FAIL bp_read_req: valid=%b write=%b addr=%h required 1 0 00006000",
                     mem_req_valid, mem_req_write, mem_req_address);
        end
        @(negedge clk);
        fill_burst(8);
        checks++;
        if (fill_valid !== 1 || fill_way !== 2'd3 || fill_beat !== 3'd7) begin
            errors++;
            $display("FAIL bp_last_fill: valid=%b way=%0d beat=%0d required 1 3 7", fill_valid, fill_way, fill_beat);
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_done: no done pulse within 10 cycles");
        end
`ifdef CACHE_MISS_SEQ_PERF_COUNTERS_EN
        checks++;
        if (perf_miss_count !== 4 || perf_wb_beat_count !== 11 || perf_stall_cycles !== 3) begin
            errors++;
            $display("FAIL perf_counts: miss=%0d wb=%0d stall=%0d required 4 11 3",
                     perf_miss_count, perf_wb_beat_count, perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_reset_mid_fill;
        bit seen;
        issue_miss(32'h0000_2000, 2'd3, 32'h0000_8000, 64'd0);
        @(negedge clk);
        fill_burst(4);
        checks++;
        if (fill_valid !== 1 || fill_beat !== 3'd3) begin
            errors++;
            $display("FAIL midrst_pre: fill_valid=%b beat=%0d required 1 3", fill_valid, fill_beat);
        end
        reset = 1;
        mem_rvalid = 1; mem_rdata = RPAT + 64'd4;
        @(negedge clk);
        reset = 0;
        checks++;
        if (miss_ready !== 1 || busy !== 0 || fill_valid !== 0) begin
            errors++;
            $display("FAIL midrst_idle: ready=%b busy=%b fill_valid=%b required 1 0 0", miss_ready, busy, fill_valid);
        end
        for (int i = 5; i < 8; i++) begin
            mem_rdata = RPAT + 64'(i);
            @(negedge clk);
            checks++;
            if (fill_valid !== 0 || mem_req_valid !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL midrst_stale%0d: fill_valid=%b req=%b busy=%b required 0 0 0",
                         i, fill_valid, mem_req_valid, busy);
            end
        end
        mem_rvalid = 0;
        issue_miss(32'h0000_3333, 2'd1, 32'h0000_8000, 64'd0);
        checks++;
        if (mem_req_valid !== 1 || mem_req_address !== 32'h0000_3300) begin
            errors++;
            $display("FAIL midrst_new_req: valid=%b addr=%h required 1 00003300", mem_req_valid, mem_req_address);
        end
        @(negedge clk);
        fill_burst(8);
        checks++;
        if (fill_valid !== 1 || fill_way !== 2'd1 || fill_beat !== 3'd7 || fill_data !== RPAT + 64'd7) begin
            errors++;
            $display("FAIL midrst_new_fill: valid=%b way=%0d beat=%0d data=%h required 1 1 7 %h",
                     fill_valid, fill_way, fill_beat, fill_data, RPAT + 64'd7);
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_new_done: no done pulse within 10 cycles");
        end
    endtask

    task automatic test_stray_rvalid;
        mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fill_valid !== 0 || miss_ready !== 1 || busy !== 0 || mem_req_valid !== 0) begin
                errors++;
                $display("FAIL stray_rvalid%0d: fill_valid=%b ready=%b busy=%b req=%b required 0 1 0 0",
                         i, fill_valid, miss_ready, busy, mem_req_valid);
            end
        end
        mem_rvalid = 0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1; miss_valid = 0; miss_address = 0; miss_way = 0; victim_address = 0;
        victim_dirty_mask = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        test_reset;
        test_clean_miss;
        test_full_dirty;
        test_sparse_dirty;
        test_backpressure;
        test_stray_rvalid;
        test_reset_mid_fill;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
